// File: rtl/voice_mix_pkg.sv
// Shared types and default sizes for the multi-voice oscillator mixer.
//   state_t        : scheduler FSM encoding
//   *_DEF          : default voice count and datapath widths
//   GAIN_W         : width of the per-voice arithmetic right-shift amount
package voice_mix_pkg;

  localparam int NUM_VOICES_DEF = 8;
  localparam int PHASE_W_DEF    = 32;
  localparam int SAMPLE_W_DEF   = 16;
  localparam int MIX_W_DEF      = 18;
  localparam int GAIN_W         = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_ACC,
    S_DONE
  } state_t;

endpackage

// File: rtl/voice_regfile.sv
// Per-voice oscillator state: phase increment, gain shift, enable and phase.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset (clears all)
//   cfg_we/cfg_voice/...     : config write port, takes effect the next cycle
//   rd_idx                   : voice currently addressed by the scheduler
//   rd_gain/rd_enable/rd_phase : combinational read of voice rd_idx
//   upd_en                   : advance phase[rd_idx] by delta[rd_idx]
module voice_regfile
  import voice_mix_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int PHASE_W    = PHASE_W_DEF,
  localparam int IDX_W     = $clog2(NUM_VOICES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_voice,
  input  logic [PHASE_W-1:0] cfg_delta,
  input  logic [GAIN_W-1:0]  cfg_gain_shift,
  input  logic               cfg_enable,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [GAIN_W-1:0]  rd_gain,
  output logic               rd_enable,
  output logic [PHASE_W-1:0] rd_phase,
  input  logic               upd_en
);

  logic [PHASE_W-1:0]    delta_q [NUM_VOICES];
  logic [PHASE_W-1:0]    delta_d [NUM_VOICES];
  logic [PHASE_W-1:0]    phase_q [NUM_VOICES];
  logic [PHASE_W-1:0]    phase_d [NUM_VOICES];
  logic [GAIN_W-1:0]     gain_q  [NUM_VOICES];
  logic [GAIN_W-1:0]     gain_d  [NUM_VOICES];
  logic [NUM_VOICES-1:0] enable_q;
  logic [NUM_VOICES-1:0] enable_d;

  always_comb begin
    delta_d  = delta_q;
    gain_d   = gain_q;
    enable_d = enable_q;
    phase_d  = phase_q;
    // Reads use the _q values, so an update in the same cycle as a config
    // write still sees the old delta.
    if (upd_en) begin
      phase_d[rd_idx] = phase_q[rd_idx] + delta_q[rd_idx];
    end
    if (cfg_we) begin
      delta_d[cfg_voice]  = cfg_delta;
      gain_d[cfg_voice]   = cfg_gain_shift;
      enable_d[cfg_voice] = cfg_enable;
      // A freshly enabled voice starts from phase 0, overriding any
      // accumulation step landing on the same voice this cycle.
      if (cfg_enable && !enable_q[cfg_voice]) begin
        phase_d[cfg_voice] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        delta_q[i] <= '0;
        gain_q[i]  <= '0;
        phase_q[i] <= '0;
      end
    end else begin
      enable_q <= enable_d;
      delta_q  <= delta_d;
      gain_q   <= gain_d;
      phase_q  <= phase_d;
    end
  end

  assign rd_gain   = gain_q[rd_idx];
  assign rd_enable = enable_q[rd_idx];
  assign rd_phase  = phase_q[rd_idx];

endmodule

// File: rtl/voice_mix_scheduler.sv
// Time-multiplexes one shared sine evaluator across NUM_VOICES oscillator
// voices once per sample period and sums the gain-shifted samples.
// Optional build macro MIX_SAT_EN: saturate the accumulator instead of
// wrapping at MIX_W bits.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   cfg_*                 : per-voice config write (delta, gain shift, enable)
//   sin_req/sin_phase     : request to the evaluator, held until sin_ack
//   sin_ack/sin_sample    : evaluator response (ack may coincide with req)
//   mix_out/mix_valid     : mixed sample and its one-cycle strobe
//   busy                  : frame in progress
//   overrun               : sticky, a period tick landed during a frame
module voice_mix_scheduler
  import voice_mix_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int PERIOD     = 2272,
  parameter int PHASE_W    = PHASE_W_DEF,
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int MIX_W      = MIX_W_DEF,
  localparam int IDX_W     = $clog2(NUM_VOICES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_voice,
  input  logic [PHASE_W-1:0]  cfg_delta,
  input  logic [GAIN_W-1:0]   cfg_gain_shift,
  input  logic                cfg_enable,
  output logic                sin_req,
  output logic [PHASE_W-1:0]  sin_phase,
  input  logic                sin_ack,
  input  logic [SAMPLE_W-1:0] sin_sample,
  output logic [MIX_W-1:0]    mix_out,
  output logic                mix_valid,
  output logic                busy,
  output logic                overrun
);

  localparam int               CNT_W    = $clog2(PERIOD);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VOICES - 1);

  function automatic logic signed [MIX_W-1:0] acc_add(
    input logic signed [MIX_W-1:0] a,
    input logic signed [MIX_W-1:0] b
  );
    logic signed [MIX_W:0] s;
    s = $signed({a[MIX_W-1], a}) + $signed({b[MIX_W-1], b});
`ifdef MIX_SAT_EN
    if (s[MIX_W] != s[MIX_W-1]) begin
      acc_add = s[MIX_W] ? {1'b1, {(MIX_W-1){1'b0}}} : {1'b0, {(MIX_W-1){1'b1}}};
    end else begin
      acc_add = s[MIX_W-1:0];
    end
`else
    acc_add = s[MIX_W-1:0];
`endif
  endfunction

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic signed [MIX_W-1:0]     acc_q, acc_d;
  logic signed [SAMPLE_W-1:0]  sample_q, sample_d;
  logic                        sin_req_q, sin_req_d;
  logic [PHASE_W-1:0]          sin_phase_q, sin_phase_d;
  logic signed [MIX_W-1:0]     mix_out_q, mix_out_d;
  logic                        mix_valid_q, mix_valid_d;
  logic                        overrun_q, overrun_d;

  logic [GAIN_W-1:0]           rd_gain;
  logic                        rd_enable;
  logic [PHASE_W-1:0]          rd_phase;
  logic                        upd_en;
  logic                        tick;
  logic signed [MIX_W-1:0]     samp_ext;
  logic signed [MIX_W-1:0]     addend;

  voice_regfile #(
    .NUM_VOICES (NUM_VOICES),
    .PHASE_W    (PHASE_W)
  ) u_regfile (
    .clk            (clk),
    .rst            (rst),
    .cfg_we         (cfg_we),
    .cfg_voice      (cfg_voice),
    .cfg_delta      (cfg_delta),
    .cfg_gain_shift (cfg_gain_shift),
    .cfg_enable     (cfg_enable),
    .rd_idx         (idx_q),
    .rd_gain        (rd_gain),
    .rd_enable      (rd_enable),
    .rd_phase       (rd_phase),
    .upd_en         (upd_en)
  );

  assign tick     = (count_q == '0);
  assign samp_ext = MIX_W'(sample_q);
  assign addend   = samp_ext >>> rd_gain;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    sample_d    = sample_q;
    sin_req_d   = sin_req_q;
    sin_phase_d = sin_phase_q;
    mix_out_d   = mix_out_q;
    mix_valid_d = 1'b0;
    upd_en      = 1'b0;
    count_d     = (count_q == CNT_MAX) ? '0 : count_q + CNT_W'(1);
    // Ticks outside IDLE are dropped; the running frame is not disturbed.
    overrun_d   = overrun_q | (tick && (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (rd_enable) begin
          // Request and phase are registered here and held for the whole
          // REQ state, independent of later phase writes.
          sin_req_d   = 1'b1;
          sin_phase_d = rd_phase;
          state_d     = S_REQ;
        end else if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_REQ: begin
        if (sin_ack) begin
          sample_d  = $signed(sin_sample);
          sin_req_d = 1'b0;
          state_d   = S_ACC;
        end
      end
      S_ACC: begin
        acc_d  = acc_add(acc_q, addend);
        upd_en = 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_CHECK;
        end
      end
      S_DONE: begin
        mix_out_d   = acc_q;
        mix_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      count_q     <= '0;
      acc_q       <= '0;
      sample_q    <= '0;
      sin_req_q   <= 1'b0;
      sin_phase_q <= '0;
      mix_out_q   <= '0;
      mix_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      sample_q    <= sample_d;
      sin_req_q   <= sin_req_d;
      sin_phase_q <= sin_phase_d;
      mix_out_q   <= mix_out_d;
      mix_valid_q <= mix_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign sin_req   = sin_req_q;
  assign sin_phase = sin_phase_q;
  assign mix_out   = mix_out_q;
  assign mix_valid = mix_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign overrun   = overrun_q;

endmodule
